// File: rtl/wb_pipe_fwd_if.sv
// Bus bundle for the write-back pipeline: issue-side inputs, forwarding lookups and slot outputs.
// master drives instructions and lookups; slave is the pipeline itself.
interface wb_pipe_fwd_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5,
    parameter int NRD    = 2
) ();
    logic                    in_valid;
    logic                    in_we;
    logic [SEL_W-1:0]        in_sel;
    logic [DATA_W-1:0]       in_data;
    logic                    stall;
    logic                    flush;
    logic [NRD*SEL_W-1:0]    rd_sel;
    logic                    out_valid;
    logic                    out_we;
    logic [SEL_W-1:0]        out_sel;
    logic [DATA_W-1:0]       out_data;
    logic [NRD-1:0]          rd_hit;
    logic [NRD*DATA_W-1:0]   rd_data;
    logic [2:0]              occ;

    modport master (
        output in_valid, in_we, in_sel, in_data, stall, flush, rd_sel,
        input  out_valid, out_we, out_sel, out_data, rd_hit, rd_data, occ
    );

    modport slave (
        input  in_valid, in_we, in_sel, in_data, stall, flush, rd_sel,
        output out_valid, out_we, out_sel, out_data, rd_hit, rd_data, occ
    );
endinterface

// File: rtl/wb_pipe_fwd.sv
// Write-back delay pipeline of DEPTH slots with youngest-first result forwarding.
// Slot 0 is youngest; slot DEPTH-1 drives the out_* ports directly.
module wb_pipe_fwd #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5,
    parameter int DEPTH  = 2,
    parameter int NRD    = 2
) (
    input  logic          clk,
    input  logic          reset,
    wb_pipe_fwd_if.slave  bus
);
    logic [DEPTH-1:0]  slot_v;
    logic [DEPTH-1:0]  slot_we;
    logic [SEL_W-1:0]  slot_sel  [DEPTH];
    logic [DATA_W-1:0] slot_data [DEPTH];

    logic [NRD-1:0]        hit;
    logic [NRD*DATA_W-1:0] fwd;
    logic [2:0]            cnt;

    // Flush outranks stall so a redirect can never be blocked by a held pipe.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_v[k]    <= 1'b0;
                slot_we[k]   <= 1'b0;
                slot_sel[k]  <= '0;
                slot_data[k] <= '0;
            end
        end else if (!bus.stall) begin
            slot_v[0]    <= bus.in_valid;
            slot_we[0]   <= bus.in_we & bus.in_valid;
            slot_sel[0]  <= bus.in_sel;
            slot_data[0] <= bus.in_data;
            for (int k = 1; k < DEPTH; k++) begin
                slot_v[k]    <= slot_v[k-1];
                slot_we[k]   <= slot_we[k-1];
                slot_sel[k]  <= slot_sel[k-1];
                slot_data[k] <= slot_data[k-1];
            end
        end
    end

    // Scan oldest to youngest so the youngest matching slot is the last to write.
    always_comb begin
        hit = '0;
        fwd = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slot_v[k] && slot_we[k] && (slot_sel[k] != '0) &&
                    (slot_sel[k] == bus.rd_sel[i*SEL_W +: SEL_W])) begin
                    hit[i]                 = 1'b1;
                    fwd[i*DATA_W +: DATA_W] = slot_data[k];
                end
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + 3'(slot_v[k]);
        end
    end

    assign bus.out_valid = slot_v[DEPTH-1];
    assign bus.out_we    = slot_we[DEPTH-1];
    assign bus.out_sel   = slot_sel[DEPTH-1];
    assign bus.out_data  = slot_data[DEPTH-1];
    assign bus.rd_hit    = hit;
    assign bus.rd_data   = fwd;
    assign bus.occ       = cnt;
endmodule

// File: tb/tb_wb_pipe_fwd.sv
// Self-checking bench for wb_pipe_fwd: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_pipe_fwd;
    localparam int DW = 32;
    localparam int SW = 5;
    localparam int DP = 2;
    localparam int NR = 2;

    logic clk;
    logic reset;
    logic [NR*SW-1:0] rsel;

    int n_pass;
    int n_total;

    wb_pipe_fwd_if #(.DATA_W(DW), .SEL_W(SW), .NRD(NR)) bus ();

    wb_pipe_fwd #(.DATA_W(DW), .SEL_W(SW), .DEPTH(DP), .NRD(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic          v;
        logic          we;
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: a queue of in-flight instructions, youngest at the front.
    always @(posedge clk) begin
        ent_t e;
        logic [NR-1:0]    e_hit;
        logic [NR*DW-1:0] e_data;
        logic [2:0]       e_occ;
        if (reset || bus.flush) begin
            foreach (mq[i]) mq[i] = '0;
        end else if (!bus.stall) begin
            e.v    = bus.in_valid;
            e.we   = bus.in_we && bus.in_valid;
            e.sel  = bus.in_sel;
            e.data = bus.in_data;
            mq.push_front(e);
            void'(mq.pop_back());
        end
        #1;
        e_hit  = '0;
        e_data = '0;
        for (int i = 0; i < NR; i++) begin
            logic [SW-1:0] want;
            want = bus.rd_sel[i*SW +: SW];
            if (want != 0) begin
                for (int k = 0; k < DP; k++) begin
                    if (!e_hit[i] && mq[k].v && mq[k].we && mq[k].sel == want) begin
                        e_hit[i] = 1'b1;
                        e_data[i*DW +: DW] = mq[k].data;
                    end
                end
            end
        end
        e_occ = '0;
        foreach (mq[k]) if (mq[k].v) e_occ++;
        chk("m_out_valid", 64'(bus.out_valid), 64'(mq[DP-1].v));
        chk("m_out_we",    64'(bus.out_we),    64'(mq[DP-1].we));
        chk("m_out_sel",   64'(bus.out_sel),   64'(mq[DP-1].sel));
        chk("m_out_data",  64'(bus.out_data),  64'(mq[DP-1].data));
        chk("m_occ",       64'(bus.occ),       64'(e_occ));
        chk("m_rd_hit",    64'(bus.rd_hit),    64'(e_hit));
        chk("m_rd_data0",  64'(bus.rd_data[DW-1:0]),  64'(e_data[DW-1:0]));
        chk("m_rd_data1",  64'(bus.rd_data[2*DW-1:DW]), 64'(e_data[2*DW-1:DW]));
    end

    task automatic step(input logic v, input logic we, input logic [SW-1:0] s,
                        input logic [DW-1:0] d, input logic st, input logic fl,
                        input logic rst);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_we    = we;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.stall    = st;
        bus.flush    = fl;
        bus.rd_sel   = rsel;
        reset        = rst;
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < DP; i++) mq.push_back('0);
        reset        = 1'b1;
        rsel         = '0;
        bus.in_valid = 1'b0;
        bus.in_we    = 1'b0;
        bus.in_sel   = '0;
        bus.in_data  = '0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.rd_sel   = '0;

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rst_occ", 64'(bus.occ), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_rd_data", 64'(bus.rd_data), 64'd0);

        // Latency
        step(1, 1, 5'd3, 32'hA5A5_0001, 0, 0, 0);
        chk("lat_occ_e1", 64'(bus.occ), 64'd1);
        chk("lat_valid_e1", 64'(bus.out_valid), 64'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lat_valid_e2", 64'(bus.out_valid), 64'd1);
        chk("lat_we_e2", 64'(bus.out_we), 64'd1);
        chk("lat_sel_e2", 64'(bus.out_sel), 64'd3);
        chk("lat_data_e2", 64'(bus.out_data), 64'hA5A5_0001);
        chk("lat_occ_e2", 64'(bus.occ), 64'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lat_valid_e3", 64'(bus.out_valid), 64'd0);
        chk("lat_occ_e3", 64'(bus.occ), 64'd0);

        // Youngest wins
        rsel = {5'd0, 5'd7};
        step(1, 1, 5'd7, 32'h11, 0, 0, 0);
        chk("yw_hit_e1", 64'(bus.rd_hit), 64'b01);
        chk("yw_data_e1", 64'(bus.rd_data[DW-1:0]), 64'h11);
        step(1, 1, 5'd7, 32'h22, 0, 0, 0);
        chk("yw_hit_e2", 64'(bus.rd_hit), 64'b01);
        chk("yw_data_e2", 64'(bus.rd_data[DW-1:0]), 64'h22);

        // Register 0 and non-writing slot never forward; sel 0 still reaches out_*
        rsel = {5'd4, 5'd0};
        step(1, 1, 5'd0, 32'hDEAD, 0, 0, 0);
        step(1, 0, 5'd4, 32'hBEEF, 0, 0, 0);
        chk("r0_hit", 64'(bus.rd_hit), 64'b00);
        chk("r0_data", 64'(bus.rd_data), 64'd0);
        chk("r0_out_we", 64'(bus.out_we), 64'd1);
        chk("r0_out_data", 64'(bus.out_data), 64'hDEAD);

        // Stall holds everything for three edges
        rsel = {5'd0, 5'd9};
        step(1, 1, 5'd9, 32'h99, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            step(1, 1, 5'd12, 32'h1200 + 32'(n), 1, 0, 0);
            chk("st_out_sel", 64'(bus.out_sel), 64'd4);
            chk("st_occ", 64'(bus.occ), 64'd2);
            chk("st_fwd9", 64'(bus.rd_data[DW-1:0]), 64'h99);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("st_out_sel9", 64'(bus.out_sel), 64'd9);
        chk("st_out_data9", 64'(bus.out_data), 64'h99);

        // Flush over stall
        rsel = {5'd11, 5'd10};
        step(1, 1, 5'd10, 32'hA0, 0, 0, 0);
        step(1, 1, 5'd11, 32'hB0, 0, 0, 0);
        chk("fl_pre_occ", 64'(bus.occ), 64'd2);
        chk("fl_pre_hit", 64'(bus.rd_hit), 64'b11);
        step(1, 1, 5'd11, 32'hC0, 1, 1, 0);
        chk("fl_occ", 64'(bus.occ), 64'd0);
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_hit", 64'(bus.rd_hit), 64'b00);

        // Reset mid-stream
        rsel = {5'd13, 5'd14};
        step(1, 1, 5'd12, 32'hC, 0, 0, 0);
        step(1, 1, 5'd13, 32'hD, 0, 0, 0);
        chk("mr_pre_occ", 64'(bus.occ), 64'd2);
        step(1, 1, 5'd15, 32'hF, 0, 0, 1);
        chk("mr_occ", 64'(bus.occ), 64'd0);
        chk("mr_out", 64'({bus.out_valid, bus.out_we, bus.out_sel, bus.out_data}), 64'd0);
        chk("mr_hit", 64'(bus.rd_hit), 64'd0);
        step(1, 1, 5'd14, 32'hE, 0, 0, 0);
        chk("mr_fwd14", 64'(bus.rd_data[DW-1:0]), 64'hE);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("mr_out_sel", 64'(bus.out_sel), 64'd14);
        chk("mr_out_data", 64'(bus.out_data), 64'hE);

        // Mixed traffic over a small register range, checked by the model only
        for (int n = 0; n < 60; n++) begin
            rsel = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wb_pipe_fwd.md
WB_PIPE_FWD -- requirements
Module: wb_pipe_fwd

Interface
REQ-001 Parameter DATA_W, default 32: result data width.
REQ-002 Parameter SEL_W, default 5: destination register select width.
REQ-003 Parameter DEPTH, default 2, legal 1..4: number of register slots (cycles of latency).
REQ-004 Parameter NRD, default 2: number of forwarding lookup ports.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  slot-0 input carries a live instruction.
REQ-008 in_we  input  1  instruction writes the register file.
REQ-009 in_sel  input  SEL_W  destination register select.
REQ-010 in_data  input  DATA_W  ALU result.
REQ-011 stall  input  1  hold all slots.
REQ-012 flush  input  1  kill all in-flight slots.
REQ-013 rd_sel  input  NRD*SEL_W  lookup selects; port i occupies bits [i*SEL_W +: SEL_W].
REQ-014 out_valid / out_we / out_sel / out_data  output  1/1/SEL_W/DATA_W  contents of slot DEPTH-1, registered.
REQ-015 rd_hit  output  NRD  port i matched an in-flight write.
REQ-016 rd_data  output  NRD*DATA_W  forwarded data per port, same packing as rd_sel.
REQ-017 occ  output  3  count of valid slots, 0..DEPTH.

Function
REQ-018 Slots 0..DEPTH-1 each hold {valid, we, sel, data}; slot 0 is youngest.
REQ-019 Priority per edge: reset > flush > stall > advance.
REQ-020 Advance: slot0 <= {in_valid, in_we & in_valid, in_sel, in_data}; slot k <= slot k-1 for k>=1.
REQ-021 Stall without flush: every slot holds; inputs are dropped (upstream holds them).
REQ-022 Flush: every slot's valid, we, sel, data <= 0 on that edge, even when stall is also high.
REQ-023 Latency: input sampled at edge N appears on the out_* ports after edge N+DEPTH-1 when no stall occurs; each stalled edge adds one cycle.
REQ-024 out_we is high only when out_valid is high.
REQ-025 Lookup is combinational from slot state and rd_sel.
- Candidate slot: valid & we & sel == rd_sel[i] & sel != 0.
REQ-026 When several slots are candidates, the lowest-index (youngest) slot drives rd_data[i].
REQ-027 No candidate: rd_hit[i]=0 and rd_data[i]=0.
REQ-028 rd_sel[i]==0 never hits (register 0 is hardwired).
REQ-029 Input ports are not searched: only registered slots forward.
REQ-030 occ equals the popcount of slot valid bits, registered consistently with slot state (combinational from slots is acceptable).
REQ-031 Writes to sel 0 propagate to out_* unchanged; only forwarding suppresses them.

Reset
REQ-032 While reset is high at an edge, all slots clear, so out_valid=0, out_we=0, out_sel=0, out_data=0, rd_hit=0, rd_data=0, occ=0.
REQ-033 Reset asserted mid-stream discards all in-flight instructions with no partial output.
REQ-034 The first edge after reset deasserts loads slot 0 normally.

Verification (DEPTH=2, NRD=2, DATA_W=32, SEL_W=5)
REQ-035 Latency check.
- Stimulus: reset, then edge 1 with in={1,1,5'd3,32'hA5A5_0001}, in_valid=0 afterward.
- Response: after edge 2, out={1,1,3,A5A5_0001}; after edge 3, out_valid=0; occ reads 1,1,0.
REQ-036 Youngest-wins forwarding.
- Stimulus: sel 7 with data 0x11 at edge 1, then sel 7 with data 0x22 at edge 2; rd_sel[0]=7.
- Response: after edge 1, rd_hit[0]=1 and rd_data=0x11; after edge 2, rd_data=0x22.
REQ-037 Register-0 and no-write lookups.
- Stimulus: slots hold {sel 0, we 1} and {sel 4, we 0}; rd_sel = {4, 0}.
- Response: rd_hit=2'b00 and both rd_data=0.
REQ-038 Stall.
- Stimulus: slot0 holds sel 9, then stall=1 for 3 edges with new inputs applied.
- Response: slot contents and out_* are unchanged for 3 cycles; after stall drops, sel 9 reaches out_* one edge later.
REQ-039 Flush over stall.
- Stimulus: occ=2, then stall=1 and flush=1 on the same edge.
- Response: occ=0, out_valid=0, and rd_hit=0 for all ports.
REQ-040 Reset mid-operation.
- Stimulus: reset=1 for 1 edge while occ=2.
- Response: all outputs are 0 next cycle; an input at the following edge emerges after 2 edges with correct data.
